// File: rtl/data_controller_gen.sv
// CPU-side glue: peripheral read mux, CPU reset hold, interrupt priority encoder
// and the audio sample latch/volume path.
module data_controller_gen #(
   parameter int NPER         = 4,
   parameter int NIRQ         = 2,
   parameter int RESET_CYCLES = 1048575,
   parameter int AUD_W        = 8,
   parameter int VOL_W        = 3
) (
   input  logic                   clk,
   input  logic                   _systemReset,
   input  logic                   cep,
   input  logic                   cen,
   input  logic [NPER-1:0]        per_sel,
   input  logic [16*NPER-1:0]     per_data,
   input  logic [15:0]            mem_data,
   output logic [15:0]            cpu_data_out,
   input  logic [NIRQ-1:0]        irq_n,
   input  logic [3*NIRQ-1:0]      irq_level,
   input  logic [NIRQ-1:0]        irq_mask,
   output logic [2:0]             _cpuIPL,
   input  logic                   soft_reset_req,
   output logic                   _cpuReset,
   input  logic                   loadSound,
   input  logic                   snd_off,
   input  logic [VOL_W-1:0]       snd_vol,
   output logic [AUD_W+VOL_W-1:0] audio_out,
   output logic                   sel_conflict
);
   localparam int            CW       = $clog2(RESET_CYCLES + 1);
   localparam logic [CW-1:0] RST_LOAD = CW'(RESET_CYCLES);

   // Declaration initialisers make the configured state match the reset state.
   logic [CW-1:0]    rst_cnt_q  = RST_LOAD;
   logic [2:0]       ipl_q      = 3'b111;
   logic             load_q     = 1'b0;
   logic [AUD_W-1:0] sample_q   = '0;
   logic             conflict_q = 1'b0;

   logic [CW-1:0]    rst_cnt_d;
   logic [2:0]       ipl_d;
   logic             load_d;
   logic [AUD_W-1:0] sample_d;
   logic             conflict_d;

   logic [15:0] per_word [NPER];
   logic [2:0]  irq_lvl  [NIRQ];
   logic [2:0]  level;
   logic        multi_sel;

   genvar gi;
   generate
      for (gi = 0; gi < NPER; gi++) begin : g_per
         assign per_word[gi] = per_data[16*gi +: 16];
      end
      for (gi = 0; gi < NIRQ; gi++) begin : g_irq
         assign irq_lvl[gi] = irq_level[3*gi +: 3];
      end
   endgenerate

   // Scan downwards so the lowest-index selected channel wins.
   always_comb begin
      cpu_data_out = mem_data;
      for (int i = NPER - 1; i >= 0; i--) begin
         if (per_sel[i]) cpu_data_out = per_word[i];
      end
   end

   always_comb begin
      level = 3'd0;
      for (int i = 0; i < NIRQ; i++) begin
         if (!irq_n[i] && !irq_mask[i] && (irq_lvl[i] > level)) level = irq_lvl[i];
      end
   end

   assign multi_sel = |(per_sel & (per_sel - NPER'(1)));

   always_comb begin
      rst_cnt_d  = rst_cnt_q;
      ipl_d      = ipl_q;
      load_d     = load_q;
      sample_d   = sample_q;
      conflict_d = conflict_q;
      if (cep) begin
         if (soft_reset_req)          rst_cnt_d = RST_LOAD;
         else if (rst_cnt_q != '0)    rst_cnt_d = rst_cnt_q - CW'(1);
         // The counter only moves on cep, so forcing here keeps the IPL fully registered.
         ipl_d = (rst_cnt_d != '0) ? 3'b111 : ~level;
         if (load_q) sample_d = snd_off ? '0 : mem_data[15 -: AUD_W];
         if (soft_reset_req) conflict_d = 1'b0;
      end
      if (cen)       load_d     = loadSound;
      if (multi_sel) conflict_d = 1'b1;
   end

   always_ff @(posedge clk or negedge _systemReset) begin
      if (!_systemReset) begin
         rst_cnt_q  <= RST_LOAD;
         ipl_q      <= 3'b111;
         load_q     <= 1'b0;
         sample_q   <= '0;
         conflict_q <= 1'b0;
      end else begin
         rst_cnt_q  <= rst_cnt_d;
         ipl_q      <= ipl_d;
         load_q     <= load_d;
         sample_q   <= sample_d;
         conflict_q <= conflict_d;
      end
   end

   assign _cpuReset    = (rst_cnt_q == '0);
   assign _cpuIPL      = ipl_q;
   assign sel_conflict = conflict_q;
   assign audio_out    = {{VOL_W{1'b0}}, sample_q} * {{AUD_W{1'b0}}, snd_vol};

endmodule

// File: tb/tb_data_controller_gen.sv
// Randomised and directed bench for data_controller_gen against a cep-counting
// reference model.
module tb_data_controller_gen;
   localparam int RC = 16;

   logic        clk = 1'b0;
   logic        _systemReset;
   logic        cep, cen;
   logic [3:0]  per_sel;
   logic [63:0] per_data;
   logic [15:0] mem_data;
   logic [15:0] cpu_data_out;
   logic [1:0]  irq_n;
   logic [5:0]  irq_level;
   logic [1:0]  irq_mask;
   logic [2:0]  _cpuIPL;
   logic        soft_reset_req;
   logic        _cpuReset;
   logic        loadSound, snd_off;
   logic [2:0]  snd_vol;
   logic [10:0] audio_out;
   logic        sel_conflict;

   data_controller_gen #(.NPER(4), .NIRQ(2), .RESET_CYCLES(RC), .AUD_W(8), .VOL_W(3)) dut (
      .clk(clk), ._systemReset(_systemReset), .cep(cep), .cen(cen),
      .per_sel(per_sel), .per_data(per_data), .mem_data(mem_data),
      .cpu_data_out(cpu_data_out), .irq_n(irq_n), .irq_level(irq_level),
      .irq_mask(irq_mask), ._cpuIPL(_cpuIPL), .soft_reset_req(soft_reset_req),
      ._cpuReset(_cpuReset), .loadSound(loadSound), .snd_off(snd_off),
      .snd_vol(snd_vol), .audio_out(audio_out), .sel_conflict(sel_conflict)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: ceps seen since the hold restarted, last sampled level, audio and flag.
   int         hold;
   logic [2:0] m_lvl;
   logic       m_load;
   logic [7:0] m_sample;
   logic       m_conf;
   logic       phase;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] ref_level();
      int lv = 0;
      for (int i = 0; i < 2; i++)
         if (!irq_n[i] && !irq_mask[i] && int'(irq_level[3*i +: 3]) > lv) lv = int'(irq_level[3*i +: 3]);
      return 3'(lv);
   endfunction

   function automatic logic [15:0] ref_mux();
      for (int i = 0; i < 4; i++) if (per_sel[i]) return per_data[16*i +: 16];
      return mem_data;
   endfunction

   task automatic model_reset();
      hold = 0; m_lvl = 3'd0; m_load = 1'b0; m_sample = 8'd0; m_conf = 1'b0;
   endtask

   task automatic model_update();
      if (!_systemReset) begin
         model_reset();
         return;
      end
      if ($countones(per_sel) >= 2) m_conf = 1'b1;
      else if (cep && soft_reset_req) m_conf = 1'b0;
      if (cep) begin
         if (soft_reset_req) hold = 0;
         else if (hold < RC) hold++;
         m_lvl = ref_level();
         if (m_load) m_sample = snd_off ? 8'd0 : mem_data[15:8];
      end
      if (cen) m_load = loadSound;
   endtask

   task automatic check_regs();
      logic [2:0] exp_ipl;
      exp_ipl = (hold >= RC) ? ~m_lvl : 3'b111;
      check_val("cpu_reset", {31'd0, _cpuReset}, {31'd0, hold >= RC});
      check_val("cpu_ipl", {29'd0, _cpuIPL}, {29'd0, exp_ipl});
      check_val("audio", {21'd0, audio_out}, 32'(int'(m_sample) * int'(snd_vol)));
      check_val("sel_conflict", {31'd0, sel_conflict}, {31'd0, m_conf});
   endtask

   // One clk cycle: cen and cep alternate, cen first.
   task automatic tick();
      cen = ~phase; cep = phase; phase = ~phase;
      #1 check_val("cpu_data", {16'd0, cpu_data_out}, {16'd0, ref_mux()});
      @(posedge clk);
      model_update();
      #1 check_regs();
   endtask

   task automatic soft_pulse();
      int g = 0;
      soft_reset_req = 1'b1;
      do begin tick(); g++; end while (!cep && g < 4);
      soft_reset_req = 1'b0;
   endtask

   task automatic count_to_release(input string tag);
      int n = 0, g = 0;
      while (!_cpuReset && g < 200) begin
         tick();
         if (cep) n++;
         g++;
      end
      check_val(tag, n, RC);
      $display("%s: %0d cep pulses until _cpuReset released", tag, n);
   endtask

   task automatic audio_load(input logic [15:0] md, input logic off);
      mem_data = md; snd_off = off; snd_vol = 3'd5; per_sel = 4'd0; loadSound = 1'b0;
      if (phase) tick();
      loadSound = 1'b1; tick();
      loadSound = 1'b0; tick();
   endtask

   task automatic rand_inputs();
      int r = $urandom_range(0, 9);
      if (r < 4)      per_sel = 4'd0;
      else if (r < 8) per_sel = 4'(1 << $urandom_range(0, 3));
      else            per_sel = 4'($urandom);
      per_data       = {$urandom, $urandom};
      mem_data       = 16'($urandom);
      irq_n          = 2'($urandom);
      irq_mask       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      if ($urandom_range(0, 15) == 0) irq_level = 6'($urandom);
      soft_reset_req = ($urandom_range(0, 149) == 0);
      loadSound      = ($urandom_range(0, 2) == 0);
      snd_off        = ($urandom_range(0, 3) == 0);
      snd_vol        = 3'($urandom);
   endtask

   initial begin
      _systemReset = 1'b0; cep = 1'b0; cen = 1'b0; phase = 1'b0;
      per_sel = 4'd0; per_data = 64'd0; mem_data = 16'd0;
      irq_n = 2'b11; irq_level = 6'd0; irq_mask = 2'd0;
      soft_reset_req = 1'b0; loadSound = 1'b0; snd_off = 1'b0; snd_vol = 3'd0;
      model_reset();
      #3;
      check_val("rst_cpu_reset", {31'd0, _cpuReset}, 32'd0);
      check_val("rst_ipl", {29'd0, _cpuIPL}, 32'd7);
      check_val("rst_audio", {21'd0, audio_out}, 32'd0);
      check_val("rst_conflict", {31'd0, sel_conflict}, 32'd0);
      tick(); tick();
      _systemReset = 1'b1;
      count_to_release("hold_after_reset");

      // Restart the hold partway through a count.
      _systemReset = 1'b0; tick(); _systemReset = 1'b1;
      begin
         int n = 0, g = 0;
         while (n < 5 && g < 40) begin tick(); if (cep) n++; g++; end
      end
      soft_pulse();
      check_val("soft_hold_low", {31'd0, _cpuReset}, 32'd0);
      count_to_release("hold_after_soft");

      per_data = {16'h0000, 16'hABCD, 16'h1234, 16'h0000};
      per_sel = 4'b0110; mem_data = 16'h5A5A;
      #1 check_val("mux_lowest", {16'd0, cpu_data_out}, 32'h1234);
      tick();
      check_val("conflict_set", {31'd0, sel_conflict}, 32'd1);
      per_sel = 4'd0;
      #1 check_val("mux_mem", {16'd0, cpu_data_out}, 32'h5A5A);
      $display("read mux: ch1 selected and memory fallback checked");

      irq_level = {3'd5, 3'd6}; irq_n = 2'b00; irq_mask = 2'b00;
      tick(); tick();
      check_val("ipl_both", {29'd0, _cpuIPL}, 32'd1);
      irq_mask = 2'b01; tick(); tick();
      check_val("ipl_mask0", {29'd0, _cpuIPL}, 32'd2);
      irq_mask = 2'b00; irq_level = {3'd5, 3'd0}; irq_n = 2'b10; tick(); tick();
      check_val("ipl_lvl0", {29'd0, _cpuIPL}, 32'd7);
      irq_level = {3'd5, 3'd6}; irq_n = 2'b11; tick(); tick();
      check_val("ipl_none", {29'd0, _cpuIPL}, 32'd7);
      $display("ipl: both/masked/level0/idle checked");

      audio_load(16'h80A5, 1'b0);
      check_val("audio_640", {21'd0, audio_out}, 32'd640);
      audio_load(16'h80A5, 1'b1);
      check_val("audio_off", {21'd0, audio_out}, 32'd0);
      $display("audio: vol 5 sample 0x80 and snd_off checked");

      soft_pulse();
      check_val("conflict_clear", {31'd0, sel_conflict}, 32'd0);

      for (int k = 0; k < 600; k++) begin
         rand_inputs();
         tick();
      end
      $display("random: 600 cycles against reference model");

      per_sel = 4'b1001; soft_reset_req = 1'b0;
      audio_load(16'h80FF, 1'b0);
      per_sel = 4'b1001; tick();
      check_val("pre_async_audio", {21'd0, audio_out}, 32'd640);
      #2 _systemReset = 1'b0;
      #1;
      check_val("async_cpu_reset", {31'd0, _cpuReset}, 32'd0);
      check_val("async_audio", {21'd0, audio_out}, 32'd0);
      check_val("async_ipl", {29'd0, _cpuIPL}, 32'd7);
      check_val("async_conflict", {31'd0, sel_conflict}, 32'd0);
      model_reset();
      per_sel = 4'd0;
      tick(); tick();
      _systemReset = 1'b1;
      count_to_release("hold_after_async");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
